// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl
//   Serialises DATA_W-bit words, LSB first, one bit per clock, and appends one
//   parity bit per frame (even or odd, chosen per word at accept time).
//   Words are accepted over a valid/ready handshake. A word offered during the
//   parity cycle is taken straight away, so frames can run back to back with no gap.
//
//   Optional feature macro: PARITY_STATS_EN. When it is defined, the design adds
//   the STAT_W parameter, the frame_cnt port and a wrapping completed-frame counter.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   in_valid   in   producer has a word on in_data
//   in_data    in   word to serialise (sampled on accept only)
//   odd_mode   in   1 = odd parity, 0 = even (sampled on accept only)
//   in_ready   out  controller can take a word this cycle
//   ser_out    out  serial bit (data LSB first, then parity); 0 when idle
//   ser_valid  out  ser_out carries a frame bit
//   ser_first  out  high with data bit 0 of each frame
//   ser_last   out  high with the parity bit of each frame
//   busy       out  frame in progress
//   frame_cnt  out  completed frames, wraps (PARITY_STATS_EN only)
module parity_frame_ctrl #(
    parameter int unsigned DATA_W = 8
`ifdef PARITY_STATS_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              odd_mode,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy
`ifdef PARITY_STATS_EN
    ,
    output logic [STAT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_e;

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              par_q,       par_d;
    logic              ser_out_q,   ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_first_q, ser_first_d;
    logic              ser_last_q,  ser_last_d;
    logic              busy_q,      busy_d;
`ifdef PARITY_STATS_EN
    logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

    logic accept;

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == PARITY);
        accept   = in_valid && in_ready;
    end

    // Next-state / datapath. The parity accumulator starts at odd_mode so that
    // after all data bits are folded in it already holds the bit to transmit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = in_data;
                    par_d   = odd_mode;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                shift_d = shift_q >> 1;
                par_d   = par_q ^ shift_q[0];
                if (cnt_q == LAST_CNT) begin
                    state_d = PARITY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = in_data;
                    par_d   = odd_mode;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered: they are derived from the next-state values so the
    // flop contents line up with the state they describe in the following cycle.
    always_comb begin
        ser_valid_d = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        ser_first_d = (state_d == SHIFT) && (cnt_d == '0);
        ser_last_d  = (state_d == PARITY);
        ser_out_d   = 1'b0;
        if (state_d == SHIFT) begin
            ser_out_d = shift_d[0];
        end else if (state_d == PARITY) begin
            ser_out_d = par_d;
        end
    end

`ifdef PARITY_STATS_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q + STAT_W'(state_q == PARITY);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PARITY_STATS_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
`ifdef PARITY_STATS_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    always_comb begin
        ser_out   = ser_out_q;
        ser_valid = ser_valid_q;
        ser_first = ser_first_q;
        ser_last  = ser_last_q;
        busy      = busy_q;
`ifdef PARITY_STATS_EN
        frame_cnt = frame_cnt_q;
`endif
    end

endmodule
